fall_scan_scheduler: RTL and testbench
======================================

# fall_scan_scheduler

Round-robin controller that shares a single `FallingDetector` comparator among `NUM_CH` patient sensor channels. It steps a channel pointer one channel per clock and feeds the selected sensor value and the factory threshold into the shared detector. It counts consecutive fall hits per channel and raises a latched alarm with the channel number once a hit is confirmed. Scanning pauses until the nurse station acknowledges. The block sits between the sensor input registers and the alarm/display logic of the health-care system.

## Interface
- `NUM_CH`, default 4: number of sensor channels, 2..16.
- `CONFIRM`, default 3: consecutive fall hits on one channel required to alarm, 1..15.
- `DATA_W`, default 8: sensor/threshold width.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: level; 1 = scanning allowed.
- `sensor_values` in `NUM_CH*DATA_W`: channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `factory_value` in `DATA_W`: threshold shared by all channels.
- `ack` in 1: alarm acknowledge; sampled only in ALARM.
- `alarm` out 1: confirmed fall pending.
- `alarm_ch` out `$clog2(NUM_CH)`: channel that caused the alarm; valid while `alarm`=1.
- `busy` out 1: 1 in SCAN or ALARM.
- `scan_round` out 1: one-cycle pulse after channel `NUM_CH-1` is compared.

## Operation
- Shared detector semantics: `fallDetected` = (`fdSensorValue` > `fdFactoryValue`), unsigned, `DATA_W` bits.
- Per-channel counter `cnt[k]`, width `$clog2(CONFIRM+1)`.
- Channel pointer `ptr` wraps from `NUM_CH-1` to 0.
- FSM states: IDLE, SCAN, ALARM.
- IDLE: `ptr`=0 and all `cnt`=0.
  - `enable`=1 at an edge -> SCAN.
- SCAN: each cycle, the detector compares `sensor_values[ptr]` against `factory_value`, and the result is applied at the next edge.
  - Hit: `cnt[ptr]` increments, saturating at `CONFIRM`.
  - Miss: `cnt[ptr]` clears to 0.
  - Otherwise `ptr` advances.
  - If the hit makes `cnt[ptr]`=`CONFIRM`: go to ALARM, latch `alarm_ch`=`ptr`, and do not advance `ptr`.
  - If `enable`=0 at an edge: the compare in flight that cycle is discarded, and the FSM goes to IDLE, clearing counters.
  - `alarm` takes priority over `enable`=0 on the same edge.
- ALARM: `alarm`=1, no compares, and counters are frozen.
  - `ack`=1 at an edge: `cnt[alarm_ch]` clears, `ptr` advances past `alarm_ch`, and the FSM goes to SCAN. If `enable`=0 on the same edge, it goes to IDLE instead.
  - `enable`=0 alone does not leave ALARM.
- `scan_round` pulses on the edge that applies the compare of channel `NUM_CH-1`. It is not asserted when the FSM leaves SCAN for ALARM or IDLE on that edge.
- `sensor_values` and `factory_value` are not registered by this block and must be stable in the cycle their channel is compared.

## Timing
- All outputs are registered.
- Reset values: `alarm`=0, `alarm_ch`=0, `busy`=0, `scan_round`=0, state IDLE, `ptr`=0, all `cnt`=0.
- `rst` overrides everything, including mid-scan and mid-alarm, and takes effect at that edge.
- Edge e0 samples `enable`=1: the FSM is in SCAN with `ptr`=0 after e0, and channel k is compared between edges e(k) and e(k+1).
- Channel k is revisited every `NUM_CH` cycles.
- Alarm latency for a steady fall on channel k, from entry to SCAN: alarm rises at edge `e(k+1+(CONFIRM-1)*NUM_CH)`.
- Ack-to-resume: one edge. The next compare is channel `alarm_ch+1` (mod `NUM_CH`).
- No combinational path from any input to any output.

## Structure
- Package `hcs_pkg`:
  - FSM state enum `fall_sched_state_t` {IDLE, SCAN, ALARM}.
  - Defaults `FALL_NUM_CH`=4 and `FALL_CONFIRM`=3.
- One sub-module: `FallingDetector`, instantiated once as the shared comparator, with ports `fdSensorValue`, `fdFactoryValue`, `fallDetected`.
- The channel mux, counters and FSM are local to this block.

## Test plan
- Reset/idle: `rst`=1 for 2 cycles with `enable`=1 -> all outputs 0.
  - Release `rst` with `enable`=0 for 10 cycles -> `busy`=0 and no `scan_round`.
- Confirmed fall, default parameters: `factory_value`=8'h00, ch2=8'h04, other channels 8'h00, `enable`=1 -> `alarm`=1 and `alarm_ch`=2 exactly at e11.
  - `scan_round` pulses at e4 and e8.
- Interrupted fall: ch1=8'h04 for its first 2 compares, then 8'h00 on the 3rd, then 8'h04 again.
  - No alarm until 3 further consecutive hits on ch1, i.e. at e22.
- Ack resume: while `alarm_ch`=2, hold ch2 high and pulse `ack` for 1 cycle.
  - `alarm`=0 at the next edge.
  - The next compare is ch3.
  - The re-alarm on ch2 occurs exactly 3 scans later, i.e. `CONFIRM*NUM_CH`=12 edges after ack.
- Boundaries:
  - ch0 and ch3 both fall -> ch0 alarms first. After ack, ch3 alarms with no extra hits beyond `CONFIRM`, since its count is frozen at 2.
  - A threshold equal to sensor (8'h04 vs 8'h04) never alarms.
- Abort paths:
  - Drop `enable` mid-scan -> IDLE and counters cleared. Re-enabling restarts at ch0 and needs a full `CONFIRM` run.
  - `rst` asserted while `alarm`=1 -> `alarm`=0 at that edge.

Source files
------------

// File: rtl/hcs_pkg.sv
// Shared types and default sizing for the fall scan scheduler.
package hcs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ALARM = 2'd2
  } fall_sched_state_t;

  localparam int FALL_NUM_CH  = 4;
  localparam int FALL_CONFIRM = 3;

endpackage

// File: rtl/FallingDetector.sv
// Shared fall comparator: a sensor reading above the factory threshold is a hit.
module FallingDetector #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] fdSensorValue,
  input  logic [DATA_W-1:0] fdFactoryValue,
  output logic              fallDetected
);

  assign fallDetected = (fdSensorValue > fdFactoryValue);

endmodule

// File: rtl/fall_scan_scheduler.sv
// Round-robin scan of NUM_CH sensor channels through one shared FallingDetector,
// with per-channel consecutive-hit counters and a latched, acknowledged alarm.
module fall_scan_scheduler
  import hcs_pkg::*;
#(
  parameter int NUM_CH  = FALL_NUM_CH,
  parameter int CONFIRM = FALL_CONFIRM,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_CH*DATA_W-1:0]   sensor_values,
  input  logic [DATA_W-1:0]          factory_value,
  input  logic                       ack,
  output logic                       alarm,
  output logic [$clog2(NUM_CH)-1:0]  alarm_ch,
  output logic                       busy,
  output logic                       scan_round,
  output logic [1:0]                 state
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(CONFIRM + 1);

  fall_sched_state_t st;
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [DATA_W-1:0] sel_value;
  logic              hit;
  logic              confirms;

  function automatic logic [PTR_W-1:0] next_ch(input logic [PTR_W-1:0] c);
    return (c == PTR_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  assign sel_value = sensor_values[int'(ptr)*DATA_W +: DATA_W];

  FallingDetector #(
    .DATA_W(DATA_W)
  ) u_detector (
    .fdSensorValue (sel_value),
    .fdFactoryValue(factory_value),
    .fallDetected  (hit)
  );

  // This hit brings the channel's run up to CONFIRM.
  assign confirms = hit && (int'(cnt[ptr]) >= CONFIRM - 1);
  assign state    = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      ptr        <= '0;
      alarm      <= 1'b0;
      alarm_ch   <= '0;
      busy       <= 1'b0;
      scan_round <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else begin
      scan_round <= 1'b0;
      case (st)
        IDLE: begin
          if (enable) begin
            st   <= SCAN;
            busy <= 1'b1;
          end
        end
        SCAN: begin
          // A confirming hit wins over a simultaneous enable drop.
          if (confirms) begin
            cnt[ptr] <= CNT_W'(CONFIRM);
            st       <= ALARM;
            alarm    <= 1'b1;
            alarm_ch <= ptr;
          end else if (!enable) begin
            st   <= IDLE;
            ptr  <= '0;
            busy <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
          end else begin
            cnt[ptr]   <= hit ? cnt[ptr] + 1'b1 : '0;
            ptr        <= next_ch(ptr);
            scan_round <= (ptr == PTR_W'(NUM_CH - 1));
          end
        end
        ALARM: begin
          if (ack) begin
            alarm         <= 1'b0;
            cnt[alarm_ch] <= '0;
            if (enable) begin
              st  <= SCAN;
              ptr <= next_ch(alarm_ch);
            end else begin
              st   <= IDLE;
              ptr  <= '0;
              busy <= 1'b0;
              for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
            end
          end
        end
        default: begin
          st    <= IDLE;
          ptr   <= '0;
          alarm <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fall_scan_scheduler.sv
// Scenario bench for fall_scan_scheduler: event scoreboard plus inline checks.
module tb_fall_scan_scheduler;
  import hcs_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int W      = 22;
  localparam logic [1:0] K_SR = 2'd1;
  localparam logic [1:0] K_AL = 2'd2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     enable;
  logic [NUM_CH*DATA_W-1:0] sv;
  logic [DATA_W-1:0]        factory_value;
  logic                     ack;
  logic                     alarm;
  logic [1:0]               alarm_ch;
  logic                     busy;
  logic                     scan_round;
  logic [1:0]               state;

  int checks = 0;
  int errors = 0;
  int edge_n = -1;
  bit mon_on = 1'b0;
  logic alarm_q = 1'b0;
  logic [W-1:0] exp_q[$];

  fall_scan_scheduler #(
    .NUM_CH (NUM_CH),
    .CONFIRM(3),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sensor_values(sv),
    .factory_value(factory_value),
    .ack          (ack),
    .alarm        (alarm),
    .alarm_ch     (alarm_ch),
    .busy         (busy),
    .scan_round   (scan_round),
    .state        (state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(input int e, input logic [1:0] k, input logic [3:0] c);
    logic [31:0] ev32;
    ev32 = e;
    return {ev32[15:0], k, c};
  endfunction

  // Event monitor: every scan_round pulse and alarm rise is matched against exp_q.
  always @(posedge clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] want;
    #1;
    if (mon_on) begin
      edge_n++;
      if (scan_round || (alarm && !alarm_q)) begin
        obs = scan_round ? ev(edge_n, K_SR, 4'd0) : ev(edge_n, K_AL, {2'b00, alarm_ch});
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected edge=%0d kind=%0d ch=%0d required no event",
                   edge_n, obs[5:4], obs[3:0]);
        end else begin
          want = exp_q.pop_front();
          if (obs !== want) begin
            errors++;
            $display("FAIL scoreboard_event got edge=%0d kind=%0d ch=%0d required edge=%0d kind=%0d ch=%0d",
                     obs[21:6], obs[5:4], obs[3:0], want[21:6], want[5:4], want[3:0]);
          end
        end
      end
    end
    alarm_q = alarm;
  end

  task automatic set_ch(input int k, input logic [DATA_W-1:0] v);
    sv[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    rst    = 1'b1;
    enable = 1'b0;
    ack    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Start scanning; the coming edge is e0.
  task automatic start_scan();
    edge_n = -1;
    mon_on = 1'b1;
    enable = 1'b1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d events left required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; ack = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (alarm !== 1'b0)      begin errors++; $display("FAIL reset_alarm got %b required 0", alarm); end
    if (alarm_ch !== 2'd0)   begin errors++; $display("FAIL reset_alarm_ch got %0d required 0", alarm_ch); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    if (scan_round !== 1'b0) begin errors++; $display("FAIL reset_scan_round got %b required 0", scan_round); end
    rst = 1'b0; enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 2;
      if (busy !== 1'b0 || scan_round !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet cycle=%0d got busy=%b scan_round=%b required 0 0", i, busy, scan_round);
      end
      if (state !== IDLE) begin
        errors++;
        $display("FAIL idle_state cycle=%0d got %0d required %0d", i, state, IDLE);
      end
    end
  endtask

  task automatic test_confirmed_fall();
    do_reset();
    factory_value = 8'h00; sv = '0; set_ch(2, 8'h04);
    exp_q.push_back(ev(4, K_SR, 4'd0));
    exp_q.push_back(ev(8, K_SR, 4'd0));
    exp_q.push_back(ev(11, K_AL, 4'd2));
    start_scan();
    repeat (11) @(negedge clk);
    checks += 2;
    if (alarm !== 1'b0) begin errors++; $display("FAIL fall_early got alarm=%b at e10 required 0", alarm); end
    if (busy !== 1'b1)  begin errors++; $display("FAIL fall_busy got %b required 1", busy); end
    @(negedge clk);
    checks += 2;
    if (alarm !== 1'b1)    begin errors++; $display("FAIL fall_alarm got %b at e11 required 1", alarm); end
    if (alarm_ch !== 2'd2) begin errors++; $display("FAIL fall_alarm_ch got %0d required 2", alarm_ch); end
    check_drained("fall");
  endtask

  // Continues from the pending ch2 alarm at e11; ack edge is e12.
  task automatic test_ack_resume();
    exp_q.push_back(ev(13, K_SR, 4'd0));
    exp_q.push_back(ev(17, K_SR, 4'd0));
    exp_q.push_back(ev(21, K_SR, 4'd0));
    exp_q.push_back(ev(24, K_AL, 4'd2));
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks += 2;
    if (alarm !== 1'b0) begin errors++; $display("FAIL ack_clear got alarm=%b required 0", alarm); end
    if (state !== SCAN) begin errors++; $display("FAIL ack_state got %0d required %0d", state, SCAN); end
    repeat (11) @(negedge clk);
    checks++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL ack_early got alarm=%b at e23 required 0", alarm); end
    @(negedge clk);
    checks += 2;
    if (alarm !== 1'b1)    begin errors++; $display("FAIL ack_realarm got %b at e24 required 1", alarm); end
    if (alarm_ch !== 2'd2) begin errors++; $display("FAIL ack_realarm_ch got %0d required 2", alarm_ch); end
    check_drained("ack");
  endtask

  task automatic test_interrupted();
    do_reset();
    factory_value = 8'h00; sv = '0; set_ch(1, 8'h04);
    for (int e = 4; e <= 20; e += 4) exp_q.push_back(ev(e, K_SR, 4'd0));
    exp_q.push_back(ev(22, K_AL, 4'd1));
    start_scan();
    repeat (9) @(negedge clk);
    set_ch(1, 8'h00);
    repeat (2) @(negedge clk);
    set_ch(1, 8'h04);
    repeat (11) @(negedge clk);
    checks++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL interrupt_early got alarm=%b at e21 required 0", alarm); end
    @(negedge clk);
    checks += 2;
    if (alarm !== 1'b1)    begin errors++; $display("FAIL interrupt_alarm got %b at e22 required 1", alarm); end
    if (alarm_ch !== 2'd1) begin errors++; $display("FAIL interrupt_alarm_ch got %0d required 1", alarm_ch); end
    check_drained("interrupt");
  endtask

  task automatic test_two_channels();
    do_reset();
    factory_value = 8'h00; sv = '0; set_ch(0, 8'h04); set_ch(3, 8'h04);
    exp_q.push_back(ev(4, K_SR, 4'd0));
    exp_q.push_back(ev(8, K_SR, 4'd0));
    exp_q.push_back(ev(9, K_AL, 4'd0));
    exp_q.push_back(ev(13, K_AL, 4'd3));
    start_scan();
    repeat (10) @(negedge clk);
    checks += 2;
    if (alarm !== 1'b1)    begin errors++; $display("FAIL two_first got alarm=%b at e9 required 1", alarm); end
    if (alarm_ch !== 2'd0) begin errors++; $display("FAIL two_first_ch got %0d required 0", alarm_ch); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL two_early got alarm=%b at e12 required 0", alarm); end
    @(negedge clk);
    checks += 2;
    if (alarm !== 1'b1)    begin errors++; $display("FAIL two_second got alarm=%b at e13 required 1", alarm); end
    if (alarm_ch !== 2'd3) begin errors++; $display("FAIL two_second_ch got %0d required 3", alarm_ch); end
    check_drained("two");
  endtask

  task automatic test_equal_threshold();
    do_reset();
    factory_value = 8'h04;
    for (int k = 0; k < NUM_CH; k++) set_ch(k, 8'h04);
    set_ch(1, 8'h03);
    for (int e = 4; e <= 36; e += 4) exp_q.push_back(ev(e, K_SR, 4'd0));
    start_scan();
    repeat (37) @(negedge clk);
    checks += 2;
    if (alarm !== 1'b0) begin errors++; $display("FAIL equal_alarm got %b required 0", alarm); end
    if (busy !== 1'b1)  begin errors++; $display("FAIL equal_busy got %b required 1", busy); end
    check_drained("equal");
  endtask

  task automatic test_enable_abort();
    do_reset();
    factory_value = 8'h00; sv = '0; set_ch(2, 8'h04);
    exp_q.push_back(ev(4, K_SR, 4'd0));
    exp_q.push_back(ev(8, K_SR, 4'd0));
    start_scan();
    repeat (10) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got %b required 0", busy); end
    if (alarm !== 1'b0) begin errors++; $display("FAIL abort_alarm got %b required 0", alarm); end
    if (state !== IDLE) begin errors++; $display("FAIL abort_state got %0d required %0d", state, IDLE); end
    repeat (3) @(negedge clk);
    check_drained("abort");
    exp_q.push_back(ev(4, K_SR, 4'd0));
    exp_q.push_back(ev(8, K_SR, 4'd0));
    exp_q.push_back(ev(11, K_AL, 4'd2));
    start_scan();
    repeat (11) @(negedge clk);
    checks++;
    if (alarm !== 1'b0) begin errors++; $display("FAIL restart_early got alarm=%b at e10 required 0", alarm); end
    @(negedge clk);
    checks += 2;
    if (alarm !== 1'b1)    begin errors++; $display("FAIL restart_alarm got %b at e11 required 1", alarm); end
    if (alarm_ch !== 2'd2) begin errors++; $display("FAIL restart_alarm_ch got %0d required 2", alarm_ch); end
    check_drained("restart");
  endtask

  // Continues from a pending alarm.
  task automatic test_reset_in_alarm();
    mon_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (alarm !== 1'b0) begin errors++; $display("FAIL rst_alarm got %b required 0", alarm); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
    if (state !== IDLE) begin errors++; $display("FAIL rst_state got %0d required %0d", state, IDLE); end
    rst = 1'b0; enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; ack = 1'b0; sv = '0; factory_value = '0;
    @(negedge clk);
    test_reset();
    test_confirmed_fall();
    test_ack_resume();
    test_interrupted();
    test_two_channels();
    test_equal_threshold();
    test_enable_abort();
    test_reset_in_alarm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
